// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: multi-cycle fetch/decode/exec/mem/writeback control for the 16-bit CPU,
// sharing one memory port between instruction fetch and LW/SW, with a bus-timeout watchdog.
module cpu_cycle_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             dec_reg_we,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_we,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_en,
    output logic             busy,
    output logic             bus_error,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERROR  = 3'd6,
        BAD    = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_error_q, bus_error_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_wr_q, mem_wr_d;
    logic             addr_sel_q, addr_sel_d;
    logic             rf_we_q, rf_we_d;
    logic             pc_en_q, pc_en_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        bus_error_d = bus_error_q;
        case (state_q)
            IDLE: begin
                state_d = start ? FETCH : IDLE;
                wait_d  = '0;
            end
            FETCH, MEM: begin
                // a ready arriving on the last permitted wait cycle still completes the request
                if (mem_ready)
                    state_d = (state_q == FETCH) ? DECODE : WB;
                else if (wait_q == WAIT_LAST)
                    state_d = ERROR;
                else
                    wait_d = wait_q + 8'd1;
            end
            DECODE: begin
                state_d = (dec_mem_rd || dec_mem_we) ? MEM : EXEC;
                wait_d  = '0;
            end
            EXEC: state_d = WB;
            WB: begin
                state_d = halt_req ? IDLE : FETCH;
                wait_d  = '0;
                cnt_d   = cnt_q + 1'b1;
            end
            ERROR: begin
                state_d     = start ? FETCH : ERROR;
                wait_d      = '0;
                bus_error_d = ~start;
            end
            default: state_d = IDLE;
        endcase
        bus_error_d = bus_error_d || (state_d == ERROR);
        // outputs are registered from the next state so they change cleanly with state_q
        mem_req_d  = (state_d == FETCH) || (state_d == MEM);
        addr_sel_d = state_d == MEM;
        mem_wr_d   = (state_d == MEM) && dec_mem_we;
        rf_we_d    = (state_d == WB) && dec_reg_we && !dec_mem_we;
        pc_en_d    = state_d == WB;
        busy_d     = (state_d != IDLE) && (state_d != ERROR) && (state_d != BAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            addr_sel_q  <= 1'b0;
            rf_we_q     <= 1'b0;
            pc_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            addr_sel_q  <= addr_sel_d;
            rf_we_q     <= rf_we_d;
            pc_en_q     <= pc_en_d;
            busy_q      <= busy_d;
        end
    end

    assign ir_we        = (state_q == FETCH) && mem_ready;
    assign mem_req      = mem_req_q;
    assign mem_wr       = mem_wr_q;
    assign mem_addr_sel = addr_sel_q;
    assign rf_we        = rf_we_q;
    assign pc_en        = pc_en_q;
    assign busy         = busy_q;
    assign bus_error    = bus_error_q;
    assign state_o      = state_q;
    assign retired_cnt  = cnt_q;
endmodule
